// File: rtl/axi3_rd_slave_pkg.sv
// Shared AXI3 read-channel types: burst/response encodings, the R-beat record
// and the responder FSM states.
package axi3_rd_slave_pkg;

    localparam int AXI3_ID_W   = 4;
    localparam int AXI3_DATA_W = 32;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi3_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi3_resp_t;

    typedef struct packed {
        logic [AXI3_ID_W-1:0]   id;
        logic [AXI3_DATA_W-1:0] data;
        axi3_resp_t             resp;
        logic                   last;
    } axi3_rd_beat_t;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } rd_state_t;

    // A WRAP container must be a power-of-two number of beats (2, 4, 8 or 16).
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi3_rd_skid_fifo.sv
// Two-entry FIFO of R beats that absorbs RAM data arriving while the initiator
// stalls. A push is accepted when full if a pop happens in the same cycle.
module axi3_rd_skid_fifo
    import axi3_rd_slave_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  axi3_rd_beat_t push_beat_i,
    input  logic          pop_i,
    output axi3_rd_beat_t head_o,
    output logic [1:0]    count_o
);

    axi3_rd_beat_t mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is never observed while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_beat_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/axi3_rd_slave.sv
// AXI3 read responder: accepts one AR burst at a time and streams R beats read
// from a synchronous RAM, with a two-entry skid buffer for R back-pressure.
module axi3_rd_slave
    import axi3_rd_slave_pkg::*;
#(
    parameter int BUS_WIDTH  = AXI3_ID_W,
    parameter int DATA_WIDTH = AXI3_DATA_W,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_WIDTH-1:0]  arid,
    input  logic [31:0]           araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [BUS_WIDTH-1:0]  rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rddata
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);

    rd_state_t             state_q, state_d;
    logic                  arready_q, arready_d;
    logic [BUS_WIDTH-1:0]  id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    axi3_burst_t           burst_q, burst_d;
    logic                  err_q, err_d;
    logic [4:0]            issue_cnt_q, issue_cnt_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  issue;
    logic                  r_fire;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [1:0]            fifo_count;
    axi3_rd_beat_t         in_beat;
    axi3_rd_beat_t         head_beat;
    axi3_rd_beat_t         out_beat;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{araddr[31:ADDR_WIDTH+LSB], araddr[LSB-1:0]};

    // WRAP keeps the bits above the container fixed and lets the low bits roll over.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input axi3_burst_t           b,
        input logic [3:0]            len
    );
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] inc;
        mask = ADDR_WIDTH'(len);
        inc  = a + ADDR_WIDTH'(1);
        case (b)
            BURST_INCR: return inc;
            BURST_WRAP: return (a & ~mask) | (inc & mask);
            default:    return a;
        endcase
    endfunction

    assign r_fire = rvalid && rready;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        burst_d     = burst_q;
        err_d       = err_q;
        issue_cnt_d = issue_cnt_q;
        issue       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arvalid && arready_q) begin
                    id_d        = arid;
                    addr_d      = araddr[ADDR_WIDTH+LSB-1:LSB];
                    len_d       = arlen;
                    burst_d     = axi3_burst_t'(arburst);
                    err_d       = (arsize != 3'(LSB)) ||
                                  (axi3_burst_t'(arburst) == BURST_RSVD) ||
                                  ((axi3_burst_t'(arburst) == BURST_WRAP) && !wrap_len_ok(arlen));
                    issue_cnt_d = 5'd0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                // At most two beats may be held between skid storage and the RAM pipe.
                if ((issue_cnt_q <= {1'b0, len_q}) &&
                    (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2)) begin
                    issue       = 1'b1;
                    addr_d      = next_addr(addr_q, burst_q, len_q);
                    issue_cnt_d = issue_cnt_q + 5'd1;
                end
                if (r_fire && out_beat.last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        arready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            arready_q       <= 1'b0;
            issue_cnt_q     <= 5'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            arready_q       <= arready_d;
            issue_cnt_q     <= issue_cnt_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (issue_cnt_q[3:0] == len_q);
        end
    end

    always_ff @(posedge clk) begin
        id_q    <= id_d;
        addr_q  <= addr_d;
        len_q   <= len_d;
        burst_q <= burst_d;
        err_q   <= err_d;
    end

    assign ram_en   = issue;
    assign ram_addr = addr_q;

    always_comb begin
        in_beat      = '0;
        in_beat.id   = id_q;
        in_beat.data = err_q ? '0 : ram_rddata;
        in_beat.resp = err_q ? RESP_SLVERR : RESP_OKAY;
        in_beat.last = inflight_last_q;
    end

    // RAM data bypasses the skid buffer when it is empty; a stalled beat is parked there.
    assign fifo_push = inflight_q && ((fifo_count != 2'd0) || !rready);
    assign fifo_pop  = (fifo_count != 2'd0) && rready;

    axi3_rd_skid_fifo u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_beat_i (in_beat),
        .pop_i       (fifo_pop),
        .head_o      (head_beat),
        .count_o     (fifo_count)
    );

    always_comb begin
        out_beat = '0;
        if (fifo_count != 2'd0) out_beat = head_beat;
        else if (inflight_q)    out_beat = in_beat;
    end

    assign rvalid  = (fifo_count != 2'd0) || inflight_q;
    assign rid     = out_beat.id;
    assign rdata   = out_beat.data;
    assign rresp   = out_beat.resp;
    assign rlast   = out_beat.last;
    assign arready = arready_q;

endmodule
